stream_wrr_arbiter_flushable: RTL and testbench
===============================================

# stream_wrr_arbiter_flushable

Weighted round-robin, packet-aware stream arbiter sharing one valid/ready output channel between N_INP requesters. Grants are locked for a whole packet (until the `last` beat handshakes). Each owner keeps the channel for up to `weight` consecutive packets before the pointer rotates. Sits where the plain flushable stream arbiter does, in front of shared memory/interconnect ports whose transactions are multi-beat and must not interleave.

## Interface
- DATA_T, logic: payload type per input.
- N_INP, 2: number of requesters; values below 2 are rejected with $fatal at elaboration.
- WEIGHT_W, 4: width of per-input weight and of the credit counter.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; drops lock, pointer and credit.
- weight_i  in  N_INP×WEIGHT_W  packets per turn per input; 0 is treated as 1.
- inp_data_i  in  N_INP×DATA_T  source payloads.
- inp_last_i  in  N_INP  last-beat flag per source.
- inp_valid_i  in  N_INP  source valid.
- inp_ready_o  out  N_INP  source ready (one-hot or zero).
- oup_data_o  out  DATA_T  selected payload.
- oup_last_o  out  1  selected last flag.
- oup_valid_o  out  1  destination valid.
- oup_ready_i  in  1  destination ready.
- idx_o  out  $clog2(N_INP)  index of the currently selected input.

## Operation
- State: state_q ∈ {ARB, LOCK}, sel_q, ptr_q, owner_q (index width), credit_q (WEIGHT_W). Reset: ARB, all fields 0.
- Pick: first index with inp_valid_i set, searching ptr_q, ptr_q+1, … with wrap modulo N_INP.
- cur = (state_q==LOCK) ? sel_q : pick. idx_o = cur. oup_data_o, oup_last_o = inputs at cur.
- oup_valid_o = !flush_i && (LOCK ? inp_valid_i[sel_q] : |inp_valid_i).
- inp_ready_o[cur] = oup_ready_i && oup_valid_o. All other bits are 0.
- Handshake hs = oup_valid_o && oup_ready_i.
- ARB→LOCK:
  - when oup_valid_o && !oup_ready_i (stalled beat), or
  - when hs with last=0;
  - sel_q <= cur in both cases.
- LOCK→ARB: on hs with last=1.
- ARB→ARB: on hs with last=1, i.e. a single-beat packet.
- Packet end (hs && last) at input i:
  - rem = (i==owner_q && credit_q!=0) ? credit_q−1 : max(weight_i[i],1)−1.
  - If rem==0: ptr_q <= (i+1) mod N_INP, credit_q <= 0.
  - Else: ptr_q <= i, owner_q <= i, credit_q <= rem.
- Work-conserving: an owner with remaining credit but no valid at packet boundary is skipped by pick. The next picked input loads fresh credit at its packet end.
- weight_i is sampled only when credit is loaded. Changes take effect on the next owner turn.
- flush_i: valid/ready forced 0 that cycle. Next state is ARB, ptr_q=0, credit_q=0, owner_q=0, sel_q=0. Flush overrides a simultaneous handshake (no handshake can occur because ready is 0).

## Timing
- Zero-cycle combinational path, valid/data in → valid/data out. No pipeline register.
- Stability: once oup_valid_o rises, idx_o and data are held until handshake, provided sources obey valid/ready, because a stall locks sel_q.
- Back-to-back packets from different inputs: allowed in consecutive cycles, with no bubble.
- If a locked source deasserts valid mid-packet (protocol violation), oup_valid_o drops and the lock is held.
- Reset asserted mid-packet: immediate ARB, outputs reflect combinational inputs with ptr 0.

## Structure
- Package stream_wrr_arbiter_pkg:
  - state enum arb_state_e {ARB, LOCK};
  - function sat_weight (0→1).
- Sub-module: the existing lzc, applied to inp_valid_i rotated by ptr_q, implements the pick. No other hierarchy.
- Index width localparam IdxW = $clog2(N_INP).

## Test plan
- Reset, N_INP=4, all weights 1, all valid, single-beat packets, ready=1 → idx_o sequence 0,1,2,3,0 in consecutive cycles.
- Input 1 sends a 3-beat packet while input 2 is valid throughout → idx_o stays 1 for 3 handshakes, then 2. Input 2 sees no ready during the burst.
- weight_i[0]=3, weight_i[1]=1, both always valid, 1-beat packets → grant pattern 0,0,0,1,0,0,0,1.
- Stall: ready=0 for 5 cycles with input 2 selected while input 0 rises → idx_o and data held at 2 until ready; input 0 is served only after.
- Owner 0 with credit 2 goes idle after packet 1, input 3 valid → next grant to 3 with a fresh credit load; ptr moves to 0 after 3's turn ends.
- flush_i pulsed in LOCK mid-burst on input 2 → that cycle valid=0 and ready=0. Next cycle state ARB, ptr 0: with inputs 1 and 2 valid, input 1 is granted.

Source files
------------

// File: rtl/stream_wrr_arbiter_pkg.sv
// rtl/stream_wrr_arbiter_pkg.sv - shared types and helpers for the weighted round-robin stream arbiter
package stream_wrr_arbiter_pkg;

  // ARB: free to pick a new source; LOCK: a packet is in flight (or a beat is stalled)
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // A weight of zero still grants one packet per turn
  function automatic int unsigned sat_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_wrr_arbiter_flushable_lzc.sv
// rtl/stream_wrr_arbiter_flushable_lzc.sv - trailing-zero counter locating the first set request bit
module stream_wrr_arbiter_flushable_lzc #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan from the top so the lowest set bit wins; zero when nothing is set
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CNT_W'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/stream_wrr_arbiter_flushable.sv
// rtl/stream_wrr_arbiter_flushable.sv - packet-locked weighted round-robin stream arbiter with flush
module stream_wrr_arbiter_flushable
  import stream_wrr_arbiter_pkg::*;
#(
  parameter type DATA_T   = logic,
  parameter int  N_INP    = 2,
  parameter int  WEIGHT_W = 4,
  localparam int IdxW     = $clog2(N_INP)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [N_INP-1:0][WEIGHT_W-1:0]   weight_i,
  input  DATA_T [N_INP-1:0]                inp_data_i,
  input  logic [N_INP-1:0]                 inp_last_i,
  input  logic [N_INP-1:0]                 inp_valid_i,
  output logic [N_INP-1:0]                 inp_ready_o,
  output DATA_T                            oup_data_o,
  output logic                             oup_last_o,
  output logic                             oup_valid_o,
  input  logic                             oup_ready_i,
  output logic [IdxW-1:0]                  idx_o
);

  if (N_INP < 2) begin : g_bad_n_inp
    $fatal(1, "stream_wrr_arbiter_flushable: N_INP must be at least 2");
  end

  arb_state_e          state_q;
  logic [IdxW-1:0]     sel_q, ptr_q, owner_q;
  logic [WEIGHT_W-1:0] credit_q;

  logic [N_INP-1:0]    rot_valid;
  logic [IdxW-1:0]     lzc_cnt;
  logic                lzc_empty;
  logic [IdxW:0]       pick_sum;
  logic [IdxW-1:0]     pick, cur, next_ptr;
  logic                hs, cur_last;
  logic [WEIGHT_W-1:0] fresh_w, rem;

  // Rotate requests so that bit 0 corresponds to the round-robin pointer
  always_comb begin
    rot_valid = '0;
    for (int k = 0; k < N_INP; k++) begin
      rot_valid[k] = inp_valid_i[IdxW'((int'(ptr_q) + k) % N_INP)];
    end
  end

  stream_wrr_arbiter_flushable_lzc #(
    .WIDTH (N_INP),
    .CNT_W (IdxW)
  ) u_lzc (
    .in_i    (rot_valid),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // Undo the rotation; with no requests the pointer itself is reported
  assign pick_sum = {1'b0, ptr_q} + {1'b0, lzc_cnt};
  assign pick     = lzc_empty ? ptr_q :
                    (pick_sum >= (IdxW+1)'(N_INP)) ? IdxW'(pick_sum - (IdxW+1)'(N_INP))
                                                   : pick_sum[IdxW-1:0];

  assign cur         = (state_q == LOCK) ? sel_q : pick;
  assign idx_o       = cur;
  assign oup_data_o  = inp_data_i[cur];
  assign cur_last    = inp_last_i[cur];
  assign oup_last_o  = cur_last;
  assign oup_valid_o = !flush_i && ((state_q == LOCK) ? inp_valid_i[sel_q] : |inp_valid_i);
  assign hs          = oup_valid_o && oup_ready_i;

  // Only the selected source may see ready, and only while the beat can move
  always_comb begin
    inp_ready_o      = '0;
    inp_ready_o[cur] = hs;
  end

  // Credit left after this packet: continue the owner's turn or start a fresh one
  assign fresh_w  = WEIGHT_W'(sat_weight(32'(weight_i[cur])));
  assign rem      = (cur == owner_q && credit_q != '0) ? credit_q - WEIGHT_W'(1)
                                                       : fresh_w - WEIGHT_W'(1);
  assign next_ptr = (cur == IdxW'(N_INP - 1)) ? '0 : cur + IdxW'(1);

  // Lock/unlock on packet boundaries and advance the weighted pointer at packet end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      sel_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else if (flush_i) begin
      state_q  <= ARB;
      sel_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (oup_valid_o && (!oup_ready_i || !cur_last)) begin
            state_q <= LOCK;
            sel_q   <= cur;
          end
        end
        LOCK: begin
          if (hs && cur_last) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
      if (hs && cur_last) begin
        if (rem == '0) begin
          ptr_q    <= next_ptr;
          credit_q <= '0;
        end else begin
          ptr_q    <= cur;
          owner_q  <= cur;
          credit_q <= rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_wrr_arbiter_flushable.sv
// tb/tb_stream_wrr_arbiter_flushable.sv - self-checking bench for the weighted round-robin stream arbiter
module tb_stream_wrr_arbiter_flushable;

  localparam int N  = 4;
  localparam int WW = 4;
  typedef logic [7:0] data_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni, flush_i, oup_ready_i;
  logic [N-1:0][WW-1:0]  weight_i;
  data_t [N-1:0]         inp_data_i;
  logic [N-1:0]          inp_last_i, inp_valid_i, inp_ready_o;
  data_t                 oup_data_o;
  logic                  oup_last_o, oup_valid_o;
  logic [1:0]            idx_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  stream_wrr_arbiter_flushable #(
    .DATA_T   (data_t),
    .N_INP    (N),
    .WEIGHT_W (WW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .weight_i    (weight_i),
    .inp_data_i  (inp_data_i),
    .inp_last_i  (inp_last_i),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .oup_data_o  (oup_data_o),
    .oup_last_o  (oup_last_o),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .idx_o       (idx_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: packet in flight, rotating pointer, current turn holder and packets left in its turn
  bit m_in_packet;
  int m_holder, m_ptr, m_turn_src, m_turn_left;
  int m_log[$];
  int d_log[$];

  function automatic int m_cur();
    if (m_in_packet) return m_holder;
    for (int k = 0; k < N; k++)
      if (inp_valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return m_ptr;
  endfunction

  function automatic bit m_valid();
    if (flush_i) return 1'b0;
    if (m_in_packet) return inp_valid_i[m_holder];
    return |inp_valid_i;
  endfunction

  int  u_src, u_left;
  bit  u_valid;
  always @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      m_in_packet = 0; m_holder = 0; m_ptr = 0; m_turn_src = 0; m_turn_left = 0;
    end else begin
      u_src   = m_cur();
      u_valid = m_valid();
      if (u_valid && oup_ready_i) m_log.push_back(u_src);
      if (u_valid && oup_ready_i && inp_last_i[u_src]) begin
        m_in_packet = 0;
        if (u_src == m_turn_src && m_turn_left > 0) u_left = m_turn_left - 1;
        else u_left = ((weight_i[u_src] == 0) ? 1 : int'(weight_i[u_src])) - 1;
        if (u_left == 0) begin
          m_ptr = (u_src + 1) % N;
          m_turn_left = 0;
        end else begin
          m_ptr = u_src;
          m_turn_src = u_src;
          m_turn_left = u_left;
        end
      end else if (u_valid) begin
        m_in_packet = 1;
        m_holder = u_src;
      end
    end
  end

  int  c_src;
  bit  c_valid;
  // Per-cycle comparison of every output against the reference
  always @(negedge clk_i) begin
    if (rst_ni) begin
      c_src   = m_cur();
      c_valid = m_valid();
      chk("valid", int'(oup_valid_o), int'(c_valid));
      chk("ready", int'(inp_ready_o), (c_valid && oup_ready_i) ? (1 << c_src) : 0);
      if (c_valid) begin
        chk("idx", int'(idx_o), c_src);
        chk("data", int'(oup_data_o), int'(inp_data_i[c_src]));
        chk("last", int'(oup_last_o), int'(inp_last_i[c_src]));
      end
      if (oup_valid_o && oup_ready_i) d_log.push_back(int'(idx_o));
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start();
    flush_i = 1'b1;
    inp_valid_i = '0;
    cyc();
    flush_i = 1'b0;
    inp_last_i = '1;
    oup_ready_i = 1'b1;
    for (int i = 0; i < N; i++) weight_i[i] = WW'(1);
    d_log.delete();
    m_log.delete();
  endtask

  task automatic check_log(input string nm, input int exp [8], input int n);
    chk({nm, "_dut_count"}, d_log.size(), n);
    chk({nm, "_model_count"}, m_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < d_log.size()) chk($sformatf("%s_dut_grant%0d", nm, i), d_log[i], exp[i]);
      if (i < m_log.size()) chk($sformatf("%s_model_grant%0d", nm, i), m_log[i], exp[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; oup_ready_i = 1'b1;
    inp_valid_i = '0; inp_last_i = '1;
    for (int i = 0; i < N; i++) begin
      weight_i[i]   = WW'(1);
      inp_data_i[i] = data_t'(8'h11 * (i + 1));
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #2;
    chk("reset_valid", int'(oup_valid_o), 0);
    chk("reset_ready", int'(inp_ready_o), 0);

    // Plain round robin, single-beat packets
    inp_valid_i = '1;
    #1;
    chk("reset_idx", int'(idx_o), 0);
    repeat (5) cyc();
    inp_valid_i = '0;
    check_log("rr", '{0, 1, 2, 3, 0, 0, 0, 0}, 5);

    // Three-beat packet on input 1 holds off input 2
    start();
    for (int k = 0; k < 4; k++) begin
      inp_valid_i   = (k < 3) ? 4'b0110 : 4'b0100;
      inp_last_i[1] = (k == 2);
      inp_data_i[1] = data_t'(8'h30 + k);
      cyc();
    end
    inp_valid_i = '0;
    check_log("burst", '{1, 1, 1, 2, 0, 0, 0, 0}, 4);

    // Weights 3 and 1
    start();
    weight_i[0] = WW'(3);
    inp_valid_i = 4'b0011;
    repeat (8) cyc();
    inp_valid_i = '0;
    check_log("weighted", '{0, 0, 0, 1, 0, 0, 0, 1}, 8);

    // Stalled beat on input 2 while input 0 comes up
    start();
    oup_ready_i = 1'b0;
    inp_valid_i = 4'b0100;
    cyc();
    inp_valid_i = 4'b0101;
    #2;
    chk("stall_idx", int'(idx_o), 2);
    chk("stall_data", int'(oup_data_o), 8'h33);
    chk("stall_ready", int'(inp_ready_o), 0);
    repeat (4) cyc();
    oup_ready_i = 1'b1;
    cyc();
    inp_valid_i = 4'b0001;
    cyc();
    inp_valid_i = '0;
    check_log("stall", '{2, 0, 0, 0, 0, 0, 0, 0}, 2);

    // Owner 0 goes idle with credit left; input 3 takes a fresh turn
    start();
    weight_i[0] = WW'(3);
    weight_i[3] = WW'(2);
    inp_valid_i = 4'b0001;
    cyc();
    inp_valid_i = 4'b1000;
    repeat (2) cyc();
    inp_valid_i = 4'b1001;
    cyc();
    inp_valid_i = '0;
    check_log("idle_owner", '{0, 3, 3, 0, 0, 0, 0, 0}, 4);

    // Flush in the middle of a packet on input 2
    start();
    inp_valid_i   = 4'b0100;
    inp_last_i[2] = 1'b0;
    cyc();
    flush_i       = 1'b1;
    inp_valid_i   = 4'b0110;
    inp_last_i[1] = 1'b1;
    #2;
    chk("flush_valid", int'(oup_valid_o), 0);
    chk("flush_ready", int'(inp_ready_o), 0);
    cyc();
    flush_i = 1'b0;
    cyc();
    inp_valid_i = '0;
    check_log("flush", '{2, 1, 0, 0, 0, 0, 0, 0}, 2);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
